// File: rtl/axis_credit_fifo.sv
// axis_credit_fifo
//   Credit-tracked AXI-Stream buffer of DEPTH entries with first-word
//   fall-through output. Each output handshake produces a one-cycle pop_o
//   pulse that returns one credit to the upstream credit counter. A sticky
//   overflow flag records any beat offered while the buffer was full. Such
//   a beat indicates broken credit accounting.
//
// Ports
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   s_tdata_i   upstream beat data
//   s_tlast_i   upstream end-of-packet
//   s_tvalid_i  upstream beat valid
//   s_tready_o  buffer can accept a beat (not full)
//   m_tdata_o   head-of-queue data
//   m_tlast_o   head-of-queue tlast
//   m_tvalid_o  queue non-empty
//   m_tready_i  downstream ready
//   pop_o       one-cycle pulse per output handshake (credit return)
//   count_o     current occupancy, 0..DEPTH
//   ovf_o       sticky: beat offered while full
module axis_credit_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 10
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [DATA_WIDTH-1:0]        s_tdata_i,
  input  logic                         s_tlast_i,
  input  logic                         s_tvalid_i,
  output logic                         s_tready_o,
  output logic [DATA_WIDTH-1:0]        m_tdata_o,
  output logic                         m_tlast_o,
  output logic                         m_tvalid_o,
  input  logic                         m_tready_i,
  output logic                         pop_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         ovf_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Each entry holds {tlast, tdata}; storage is deliberately not reset.
  logic [DATA_WIDTH:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             ovf_q,    ovf_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic [DATA_WIDTH:0] head;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Readiness depends only on registered occupancy, so a pop in the same
  // cycle never opens space for a push while full.
  assign s_tready_o = ~full;
  assign m_tvalid_o = ~empty;

  assign push = s_tvalid_i & ~full;
  assign pop  = ~empty & m_tready_i;

  assign head      = mem_q[rd_ptr_q];
  assign m_tdata_o = head[DATA_WIDTH-1:0];
  assign m_tlast_o = head[DATA_WIDTH];
  assign pop_o     = pop;
  assign count_o   = count_q;
  assign ovf_o     = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (s_tvalid_i & full);

    // Explicit wrap so DEPTH need not be a power of two.
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // A push can never land on the head entry: when full, push is blocked,
  // so wr_ptr differs from rd_ptr whenever the head is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_tlast_i, s_tdata_i};
    end
  end

endmodule

// File: tb/tb_axis_credit_fifo.sv
// Bench for axis_credit_fifo.
module tb_axis_credit_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 10;
  localparam int unsigned CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_tdata;
  logic          s_tlast;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic          pop;
  logic [CW-1:0] count;
  logic          ovf;

  axis_credit_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .s_tdata_i  (s_tdata),
    .s_tlast_i  (s_tlast),
    .s_tvalid_i (s_tvalid),
    .s_tready_o (s_tready),
    .m_tdata_o  (m_tdata),
    .m_tlast_o  (m_tlast),
    .m_tvalid_o (m_tvalid),
    .m_tready_i (m_tready),
    .pop_o      (pop),
    .count_o    (count),
    .ovf_o      (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected output beats {tlast, tdata}.
  logic [DW:0] exp_q [$];
  int  mcount = 0;     // expected occupancy
  bit  movf   = 1'b0;  // expected sticky overflow
  int  pops   = 0;     // pop_o pulses observed

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a beat that the
  // downstream side accepts this cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("mon_unexpected_beat", {23'd0, m_tlast, m_tdata}, 32'h1ff);
        end else begin
          chk("mon_beat", {23'd0, m_tlast, m_tdata}, {23'd0, exp_q[0]});
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // One clock cycle of stimulus. Called at posedge+1; checks outputs at the
  // negedge against the bench model, then advances the model at posedge.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit l, input bit rdy);
    bit full, do_push, do_pop;
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
    m_tready = rdy;
    full    = (mcount == DEPTH);
    do_push = v && !full;
    do_pop  = rdy && (mcount != 0);
    if (do_push) exp_q.push_back({l, d});
    @(negedge clk);
    chk("s_tready", {31'd0, s_tready}, {31'd0, !full});
    chk("m_tvalid", {31'd0, m_tvalid}, {31'd0, mcount != 0});
    chk("pop_o",    {31'd0, pop},      {31'd0, do_pop});
    chk("count_o",  {28'd0, count},    mcount);
    chk("ovf_o",    {31'd0, ovf},      {31'd0, movf});
    if (mcount != 0 && exp_q.size() != 0)
      chk("head", {23'd0, m_tlast, m_tdata}, {23'd0, exp_q[0]});
    if (pop) pops++;
    @(posedge clk);
    mcount = mcount + int'(do_push) - int'(do_pop);
    if (v && full) movf = 1'b1;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && mcount != 0; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    rst      = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 8'h11;
    s_tlast  = 1'b0;
    m_tready = 1'b0;

    // Reset with s_tvalid held high.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", {31'd0, s_tready}, 32'd1);
    chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_count",    {28'd0, count},    32'd0);
    chk("rst_pop",      {31'd0, pop},      32'd0);
    chk("rst_ovf",      {31'd0, ovf},      32'd0);
    rst = 1'b0;

    // First beat after release.
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("first_beat_data", {24'd0, m_tdata}, 32'h11);
    drain();

    // Fill to DEPTH, overflow attempt, then drain in order.
    for (int i = 1; i <= int'(DEPTH); i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("full_count", {28'd0, count}, DEPTH);
    chk("ovf_set",    {31'd0, ovf},   32'd1);
    pops = 0;
    drain();
    chk("fill_drain_pops", pops, DEPTH);
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);

    // Wrap-around: alternating bursts of 7 pushes / 7 pops, 25 beats.
    begin
      int sent = 0;
      while (sent < 25) begin
        int n = (25 - sent < 7) ? 25 - sent : 7;
        for (int i = 0; i < n; i++) cycle(1'b1, DW'(8'h80 + sent + i), 1'(i == n - 1), 1'b0);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        sent += n;
      end
    end
    chk("wrap_empty", {28'd0, count}, 32'd0);

    // Streaming at occupancy 3.
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'h30 + i), 1'b0, 1'b0);
    pops = 0;
    for (int i = 0; i < 50; i++) cycle(1'b1, DW'(8'h40 + i), 1'(i % 5 == 4), 1'b1);
    chk("stream_pops",  pops,             32'd50);
    chk("stream_count", {28'd0, count},   32'd3);
    drain();

    // Backpressure: head 0x5A with tlast, held while pushing behind it.
    cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, DW'(8'hA0 + i), 1'b0, 1'b0);
    chk("bp_head_data", {24'd0, m_tdata}, 32'h5A);
    chk("bp_head_last", {31'd0, m_tlast}, 32'd1);
    drain();

    // Asynchronous reset mid-cycle at occupancy 6.
    for (int i = 0; i < 6; i++) cycle(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    #2;
    rst = 1'b1;
    exp_q.delete();
    mcount = 0;
    movf   = 1'b0;
    #1;
    chk("arst_s_tready", {31'd0, s_tready}, 32'd1);
    chk("arst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("arst_count",    {28'd0, count},    32'd0);
    chk("arst_pop",      {31'd0, pop},      32'd0);
    chk("arst_ovf",      {31'd0, ovf},      32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    chk("post_rst_head", {24'd0, m_tdata}, 32'h77);
    cycle(1'b1, 8'h78, 1'b0, 1'b0);
    drain();
    chk("final_scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
